fifo_uart_tx: RTL and testbench
===============================

// Module: fifo_uart_tx
// PURPOSE
//  Read-side consumer of the async FIFO, in the UART TX clock domain.
//  Pops one byte whenever the FIFO is non-empty and serialises it as a UART frame:
//  start, DATA_WIDTH data bits LSB first, optional parity, stop.
//  Sends back-to-back frames with no idle bit while data remains.
// PARAMETERS
//  DATA_WIDTH   8   FIFO word width and UART data bits per frame
// PORTS
//  i_clk       in   1            TX clock; one UART bit per cycle; same clock as FIFO read side
//  i_rst_n     in   1            asynchronous, active-low reset
//  i_rdata     in   DATA_WIDTH   FIFO read data, first-word-fall-through (valid while i_empty=0)
//  i_empty     in   1            FIFO empty flag, already synchronised to i_clk
//  i_par_en    in   1            parity enable (UART_TX_PARITY_EN builds only)
//  i_par_typ   in   1            0=even, 1=odd (UART_TX_PARITY_EN builds only)
//  o_rinc      out  1            FIFO pop strobe, exactly one cycle per byte consumed
//  o_tx        out  1            serial line, registered, idles high
//  o_busy      out  1            high from start bit through stop bit
// BEHAVIOUR
//  Reset values: o_tx=1, o_rinc=0, o_busy=0, FSM=IDLE, bit counter=0, shift reg=0.
//  FSM states: IDLE, START, DATA, PARITY, STOP.
//  Load event, cycle N:
//   - occurs in IDLE, or in the last STOP cycle, when i_empty=0;
//   - o_rinc=1 (combinational from state and i_empty);
//   - i_rdata latched into the shift register; parity computed and latched;
//   - i_par_en/i_par_typ sampled (held constant for the whole frame).
//  Cycle N+1: START, o_tx=0, o_busy=1.
//  DATA: DATA_WIDTH cycles, o_tx=shift[0], shift right each cycle, 3-bit counter 0..DATA_WIDTH-1.
//   When the counter reaches DATA_WIDTH-1: go to PARITY if parity is enabled, else STOP.
//  PARITY: one cycle, o_tx = ^data ^ i_par_typ (latched values).
//  STOP: one cycle, o_tx=1.
//   Then load event if i_empty=0 (next cycle START, no gap), else IDLE (o_busy=0).
//  Frame length: 10 cycles (no parity) or 11 (parity).
//  Latency: pop at N, start bit at N+1.
//  i_empty=1: o_rinc never asserts, so the FIFO is never popped while empty.
//  i_rdata is ignored outside the load cycle.
//  i_empty rising mid-frame: no effect; only the STOP-cycle decision uses it.
//  Async reset mid-frame: outputs return to reset values at once, and the popped byte is discarded.
//   The FIFO is unaffected, since its pointer already advanced.
// CONFIGURATION
//  `UART_TX_PARITY_EN defined:
//   - i_par_en and i_par_typ exist; the PARITY state is reachable when i_par_en=1.
//  `UART_TX_PARITY_EN undefined:
//   - both ports removed; PARITY state and parity register not synthesised;
//   - frames are fixed 8N1 (10 cycles).
// STRUCTURE
//  Package fifo_uart_pkg:
//   - state enum (IDLE/START/DATA/PARITY/STOP);
//   - PAR_EVEN=0 and PAR_ODD=1 constants;
//   - LINE_IDLE=1 and START_BIT=0 constants.
//  One sub-module, uart_parity_calc: combinational (data, par_typ) -> parity bit.
//   It is instantiated only under `UART_TX_PARITY_EN.
//  Top level: FSM, bit counter, shift register, o_tx register.
// TESTING
//  1. Reset with i_empty=1 for 20 cycles -> o_tx=1, o_rinc=0, o_busy=0 throughout.
//  2. No parity; present 0xA5, drop i_empty for 1 cycle ->
//     o_rinc single pulse; o_tx = 0,1,0,1,0,0,1,0,1,1 over the next 10 cycles; then IDLE.
//  3. Parity on, 0xA5: even -> parity bit 0; odd -> parity bit 1; frame 11 cycles.
//  4. Bytes 0x00, 0xFF, 0x3C held non-empty ->
//     3 o_rinc pulses spaced 10 cycles apart; stop bit directly followed by start bit;
//     o_busy continuously high for 30 cycles.
//  5. Assert i_rst_n=0 during bit 4 of 0x5A -> o_tx=1 and o_busy=0 immediately.
//     After release with i_empty=0, the next FIFO word is popped and sent complete.
//  6. Scoreboard: write 16 random bytes with bursty writes into ASYNC_FIFO (W 10ns, R 25ns).
//     Decode o_tx -> all 16 bytes in order, no duplicates, no pops while empty.

Source files
------------

// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
`timescale 1ns/1ps
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;

endpackage

// File: rtl/uart_parity_calc.sv
// Combinational parity generator: even or odd parity over one data word.
`timescale 1ns/1ps
module uart_parity_calc
  import fifo_uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_par_typ,
  output logic                  o_par
);

  assign o_par = (^i_data) ^ (i_par_typ == PAR_ODD);

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO read-side UART transmitter: pops one byte per frame, sends back-to-back frames.
// Optional parity bit is built only when UART_TX_PARITY_EN is defined.
`timescale 1ns/1ps
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  i_empty,
`ifdef UART_TX_PARITY_EN
  input  logic                  i_par_en,
  input  logic                  i_par_typ,
`endif
  output logic                  o_rinc,
  output logic                  o_tx,
  output logic                  o_busy
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  tx_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  run_q;
  logic                  load;

`ifdef UART_TX_PARITY_EN
  logic par_en_q, par_en_d;
  logic par_bit_q, par_bit_d;
  logic par_calc;

  uart_parity_calc #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_parity (
    .i_data   (i_rdata),
    .i_par_typ(i_par_typ),
    .o_par    (par_calc)
  );
`endif

  // NOTE: run_q keeps o_rinc low until the first clock after reset release, so a
  // non-empty FIFO is never popped while this block is held in reset.
  assign load = run_q && !i_empty && ((state_q == IDLE) || (state_q == STOP));

  // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    tx_d    = tx_q;
`ifdef UART_TX_PARITY_EN
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
`endif
    unique case (state_q)
      IDLE: tx_d = LINE_IDLE;
      START: begin
        state_d = DATA;
        cnt_d   = '0;
        tx_d    = shift_q[0];
        shift_d = shift_q >> 1;
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
`ifdef UART_TX_PARITY_EN
          if (par_en_q) begin
            state_d = PARITY;
            tx_d    = par_bit_q;
          end else begin
            state_d = STOP;
            tx_d    = LINE_IDLE;
          end
`else
          state_d = STOP;
          tx_d    = LINE_IDLE;
`endif
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        state_d = STOP;
        tx_d    = LINE_IDLE;
      end
`endif
      STOP: begin
        state_d = IDLE;
        tx_d    = LINE_IDLE;
      end
      default: begin
        state_d = IDLE;
        tx_d    = LINE_IDLE;
      end
    endcase

    // A load overrides the per-state decision, giving a start bit right after STOP.
    if (load) begin
      state_d = START;
      cnt_d   = '0;
      shift_d = i_rdata;
      tx_d    = START_BIT;
`ifdef UART_TX_PARITY_EN
      par_en_d  = i_par_en;
      par_bit_d = par_calc;
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      tx_q    <= LINE_IDLE;
      run_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      run_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
`endif
    end
  end

  assign o_rinc = load;
  assign o_tx   = tx_q;
  assign o_busy = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed self-checking bench for fifo_uart_tx with a FWFT FIFO model and line decoder.
// Parity frames are exercised when UART_TX_PARITY_EN is defined.
`timescale 1ns/1ps
module tb_fifo_uart_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rdata = 8'h00;
  logic       empty = 1'b1;
  logic       rinc, tx, busy;
`ifdef UART_TX_PARITY_EN
  logic       par_en = 1'b0;
  logic       par_typ = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fifo_uart_tx #(
    .DATA_WIDTH(8)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_rdata(rdata),
    .i_empty(empty),
`ifdef UART_TX_PARITY_EN
    .i_par_en (par_en),
    .i_par_typ(par_typ),
`endif
    .o_rinc (rinc),
    .o_tx   (tx),
    .o_busy (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return b[idx-1];
  endfunction

  // Entered in an idle cycle; exp_bits[i] is the line value in the i-th cycle after the pop.
  task automatic run_frame(input string tag, input logic [7:0] b, input int len,
                           input logic [15:0] exp_bits);
    rdata = b;
    empty = 1'b0;
    #1;
    check({tag, "_rinc_load"}, rinc, 1);
    check({tag, "_tx_load"}, tx, 1);
    next_cycle();
    empty = 1'b1;
    rdata = ~b;
    #1;
    for (int i = 0; i < len; i++) begin
      check({tag, "_tx"}, tx, exp_bits[i]);
      check({tag, "_busy"}, busy, 1);
      check({tag, "_rinc"}, rinc, 0);
      next_cycle();
    end
    check({tag, "_tx_after"}, tx, 1);
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_rinc_after"}, rinc, 0);
  endtask

  logic [7:0] burst_bytes [3];
  logic [7:0] fifo_q [$];
  logic [7:0] sent_q [$];
  logic [7:0] rx_q [$];

  initial begin
    logic       exp_tx;
    int         pops;
    int         pushed;
    int         burst_left;
    int         cyc;
    logic       rx_active;
    int         rx_idx;
    logic [7:0] rx_byte;
    logic [7:0] nb;

    // 1: reset state, then idle with an empty FIFO.
    repeat (3) next_cycle();
    check("rst_tx", tx, 1);
    check("rst_rinc", rinc, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      check("idle_tx", tx, 1);
      check("idle_rinc", rinc, 0);
      check("idle_busy", busy, 0);
      next_cycle();
    end

    // 2: single 0xA5 frame, 8N1: 0,1,0,1,0,0,1,0,1,1.
    run_frame("a5", 8'hA5, 10, 16'b11_0100_1010);

`ifdef UART_TX_PARITY_EN
    // 3: 0xA5 with even (parity 0) and odd (parity 1) parity, 11-cycle frames.
    par_en  = 1'b1;
    par_typ = 1'b0;
    run_frame("a5_even", 8'hA5, 11, 16'b101_0100_1010);
    par_typ = 1'b1;
    run_frame("a5_odd", 8'hA5, 11, 16'b111_0100_1010);
    par_en  = 1'b0;
    par_typ = 1'b0;
    next_cycle();
`endif

    // 4: three bytes back to back, pops at cycles 0, 10, 20.
    burst_bytes[0] = 8'h00;
    burst_bytes[1] = 8'hFF;
    burst_bytes[2] = 8'h3C;
    for (int k = 0; k < 32; k++) begin
      pops  = int'(k > 0) + int'(k > 10) + int'(k > 20);
      empty = (pops == 3);
      rdata = (pops < 3) ? burst_bytes[pops] : 8'hEE;
      #1;
      if (k == 0 || k == 31) exp_tx = 1'b1;
      else exp_tx = frame_bit(burst_bytes[(k-1)/10], (k-1)%10);
      check("b2b_rinc", rinc, (k == 0 || k == 10 || k == 20));
      check("b2b_tx", tx, exp_tx);
      check("b2b_busy", busy, (k >= 1 && k <= 30));
      next_cycle();
    end

    // 5: reset during data bit 4 of 0x5A, then the next word goes out whole.
    rdata = 8'h5A;
    empty = 1'b0;
    #1;
    check("rst5_rinc_load", rinc, 1);
    next_cycle();
    empty = 1'b1;
    repeat (5) next_cycle();
    check("rst5_bit4", tx, 1);
    check("rst5_busy_pre", busy, 1);
    rdata = 8'hC3;
    empty = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst5_tx", tx, 1);
    check("rst5_busy", busy, 0);
    check("rst5_rinc", rinc, 0);
    next_cycle();
    check("rst5_rinc_held", rinc, 0);
    rst_n = 1'b1;
    #1;
    check("rst5_rinc_release", rinc, 0);
    check("rst5_busy_release", busy, 0);
    next_cycle();
    run_frame("c3", 8'hC3, 10, 16'b11_1000_0110);

    // 6: random bytes, bursty writes into a FWFT FIFO model, line decoded back.
    pushed     = 0;
    burst_left = 0;
    rx_active  = 1'b0;
    rx_idx     = 0;
    rx_byte    = 8'h00;
    cyc        = 0;
    while (rx_q.size() < 16 && cyc < 3000) begin
      if (pushed < 16) begin
        if (burst_left == 0 && $urandom_range(0, 3) == 0) burst_left = $urandom_range(1, 4);
        if (burst_left > 0) begin
          nb = 8'($urandom_range(0, 255));
          fifo_q.push_back(nb);
          sent_q.push_back(nb);
          pushed++;
          burst_left--;
        end
      end
      empty = (fifo_q.size() == 0);
      rdata = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
      #1;
      check("rnd_pop_while_empty", {31'b0, rinc & empty}, 0);
      if (!rx_active) begin
        if (tx == 1'b0) begin
          rx_active = 1'b1;
          rx_idx    = 0;
        end
      end else if (rx_idx < 8) begin
        rx_byte[rx_idx] = tx;
        rx_idx++;
      end else begin
        check("rnd_stop_bit", tx, 1);
        rx_q.push_back(rx_byte);
        rx_active = 1'b0;
      end
      if (rinc && fifo_q.size() > 0) void'(fifo_q.pop_front());
      next_cycle();
      cyc++;
    end
    check("rnd_rx_count", rx_q.size(), 16);
    check("rnd_fifo_drained", fifo_q.size(), 0);
    for (int i = 0; i < 16; i++) begin
      if (i < rx_q.size()) check("rnd_byte", rx_q[i], sent_q[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
